// File: rtl/mskaes_128bits_ks_ctrl.sv
// Key-state holder and round sequencer for the masked AES-128 key schedule.
// Key paths are share-wise registers and muxes only; shares are never recombined.
module mskaes_128bits_ks_ctrl #(
  parameter int d        = 2,
  parameter int SBOX_LAT = 4,
  parameter int NROUNDS  = 10
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [128*d-1:0]     sh_key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic [128*d-1:0]     sh_ks_key,
  input  logic [128*d-1:0]     sh_ks_next,
  output logic                 ks_data_valid,
  output logic                 ks_rcon_update,
  output logic                 ks_rcon_rst,
  output logic                 ks_active,
  output logic [128*d-1:0]     sh_round_key,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [3:0]           rk_index,
  output logic                 rk_last
);

  localparam int CW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t             state_reg;
  logic [128*d-1:0]   key_reg;
  logic [3:0]         round_reg;
  logic [CW-1:0]      cnt_reg;
  logic               key_ready_reg;
  logic               rk_valid_reg;
  logic               rk_last_reg;
  logic               ks_data_valid_reg;
  logic               ks_rcon_update_reg;
  logic               ks_active_reg;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg          <= IDLE;
      key_reg            <= '0;
      round_reg          <= 4'd0;
      cnt_reg            <= '0;
      key_ready_reg      <= 1'b1;
      rk_valid_reg       <= 1'b0;
      rk_last_reg        <= 1'b0;
      ks_data_valid_reg  <= 1'b0;
      ks_rcon_update_reg <= 1'b0;
      ks_active_reg      <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (key_valid) begin
            key_reg       <= sh_key_in;
            round_reg     <= 4'd0;
            key_ready_reg <= 1'b0;
            rk_valid_reg  <= 1'b1;
            rk_last_reg   <= (NROUNDS == 0);
            state_reg     <= EMIT;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            rk_valid_reg <= 1'b0;
            rk_last_reg  <= 1'b0;
            if (round_reg == 4'(NROUNDS)) begin
              key_ready_reg <= 1'b1;
              state_reg     <= IDLE;
            end else begin
              ks_data_valid_reg <= 1'b1;
              ks_active_reg     <= 1'b1;
              state_reg         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          ks_data_valid_reg  <= 1'b0;
          cnt_reg            <= CW'(SBOX_LAT - 1);
          // The rcon update pulse must line up with the capture cycle.
          ks_rcon_update_reg <= (SBOX_LAT == 1);
          state_reg          <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            key_reg            <= sh_ks_next;
            round_reg          <= (round_reg == 4'(NROUNDS)) ? round_reg : round_reg + 4'd1;
            rk_last_reg        <= (round_reg + 4'd1 == 4'(NROUNDS));
            rk_valid_reg       <= 1'b1;
            ks_rcon_update_reg <= 1'b0;
            ks_active_reg      <= 1'b0;
            state_reg          <= EMIT;
          end else begin
            cnt_reg            <= cnt_reg - CW'(1);
            ks_rcon_update_reg <= (cnt_reg == CW'(1));
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // rcon must restart during reset and on the load edge so it reads 0x01 for round 1.
  assign ks_rcon_rst    = !nrst || (key_ready_reg && key_valid);

  assign key_ready      = key_ready_reg;
  assign sh_ks_key      = key_reg;
  assign sh_round_key   = key_reg;
  assign ks_data_valid  = ks_data_valid_reg;
  assign ks_rcon_update = ks_rcon_update_reg;
  assign ks_active      = ks_active_reg;
  assign rk_valid       = rk_valid_reg;
  assign rk_index       = round_reg;
  assign rk_last        = rk_last_reg;

endmodule

// File: tb/tb_mskaes_128bits_ks_ctrl.sv
// Bench for mskaes_128bits_ks_ctrl with a behavioural masked key-schedule model
// that presents the next key only in the cycle the S-box output is valid.
module tb_mskaes_128bits_ks_ctrl;

  localparam int D   = 2;
  localparam int LAT = 4;
  localparam int NR  = 10;
  localparam int W   = 128 * D;

  logic          clk = 1'b0;
  logic          nrst;
  logic [W-1:0]  sh_key_in;
  logic          key_valid;
  logic          key_ready;
  logic [W-1:0]  sh_ks_key;
  logic [W-1:0]  sh_ks_next;
  logic          ks_data_valid;
  logic          ks_rcon_update;
  logic          ks_rcon_rst;
  logic          ks_active;
  logic [W-1:0]  sh_round_key;
  logic          rk_valid;
  logic          rk_ready;
  logic [3:0]    rk_index;
  logic          rk_last;

  always #5 clk = ~clk;

  mskaes_128bits_ks_ctrl #(.d(D), .SBOX_LAT(LAT), .NROUNDS(NR)) dut (
    .clk(clk), .nrst(nrst), .sh_key_in(sh_key_in), .key_valid(key_valid),
    .key_ready(key_ready), .sh_ks_key(sh_ks_key), .sh_ks_next(sh_ks_next),
    .ks_data_valid(ks_data_valid), .ks_rcon_update(ks_rcon_update),
    .ks_rcon_rst(ks_rcon_rst), .ks_active(ks_active), .sh_round_key(sh_round_key),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_index(rk_index), .rk_last(rk_last)
  );

  typedef struct {
    logic [3:0]   idx;
    logic         last;
    logic [127:0] rk;
  } rk_vec_t;

  rk_vec_t fips_tbl[11];
  rk_vec_t zero_tbl[11];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    repeat (254) r = gmul(r, x);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  // Key words in FIPS order: w0 is the most significant 32 bits.
  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rw, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    rw = {w3[23:0], w3[31:24]};
    t  = {sbox(rw[31:24]) ^ rc, sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // AES byte i is k[127-8i -: 8]; its bit b lives at shared[8*D*i + b*D +: D].
  function automatic logic [W-1:0] share(input logic [127:0] k);
    logic [W-1:0] sh;
    logic [7:0]   byt;
    logic         acc, r;
    sh = '0;
    for (int i = 0; i < 16; i++) begin
      byt = k[127-8*i -: 8];
      for (int b = 0; b < 8; b++) begin
        acc = 1'b0;
        for (int s = 0; s < D - 1; s++) begin
          r = 1'($urandom_range(0, 1));
          sh[8*D*i + b*D + s] = r;
          acc = acc ^ r;
        end
        sh[8*D*i + b*D + D - 1] = byt[b] ^ acc;
      end
    end
    return sh;
  endfunction

  function automatic logic [127:0] unmask(input logic [W-1:0] sh);
    logic [127:0] k;
    logic [7:0]   byt;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 8; b++) byt[b] = ^sh[8*D*i + b*D +: D];
      k[127-8*i -: 8] = byt;
    end
    return k;
  endfunction

  // Behavioural KS: rcon register plus a latency counter from data_in_valid.
  logic [7:0]   rcon_m = 8'h01;
  logic [127:0] pend_k = '0;
  logic         pend   = 1'b0;
  int           cnt_m  = 0;

  always @(posedge clk) begin
    if (ks_rcon_rst || ks_rcon_update)
      check("rcon_pulses_exclusive", {ks_rcon_rst, ks_rcon_update} == 2'b11, '0);
    if (ks_rcon_rst) rcon_m = 8'h01;
    else if (ks_rcon_update) rcon_m = {rcon_m[6:0], 1'b0} ^ (rcon_m[7] ? 8'h1b : 8'h00);
    if (!nrst) pend = 1'b0;
    else if (pend && cnt_m > 0) cnt_m--;
    else if (pend) pend = 1'b0;
    if (nrst && ks_data_valid) begin
      pend   = 1'b1;
      pend_k = unmask(sh_ks_key);
      cnt_m  = LAT - 1;
    end
  end

  always @(negedge clk) begin
    if (pend && cnt_m == 0) begin
      sh_ks_next = share(expand(pend_k, rcon_m));
    end else begin
      for (int j = 0; j < W / 32; j++) sh_ks_next[32*j +: 32] = $urandom();
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k, input string tag);
    int budget;
    budget = 0;
    while (!key_ready && budget < 50) begin
      tick();
      budget++;
    end
    check({tag, "_key_ready"}, key_ready, 1'b1);
    sh_key_in = share(k);
    key_valid = 1'b1;
    #1;
    check({tag, "_rcon_rst_on_load"}, ks_rcon_rst, 1'b1);
    tick();
    key_valid = 1'b0;
  endtask

  // Walk a full schedule: check each round key, then time the next issue/capture.
  task automatic run_keys(input int which, input int hold_at, input int inject_at,
                          input int reset_at, input string tag);
    rk_vec_t      v;
    logic [W-1:0] snap;
    for (int r = 0; r <= NR; r++) begin
      v = (which == 0) ? fips_tbl[r] : zero_tbl[r];
      check($sformatf("%s_r%0d_rk_valid", tag, r), rk_valid, 1'b1);
      check($sformatf("%s_r%0d_rk_index", tag, r), rk_index, v.idx);
      check($sformatf("%s_r%0d_key", tag, r), unmask(sh_round_key), v.rk);
      check($sformatf("%s_r%0d_rk_last", tag, r), rk_last, v.last);
      check($sformatf("%s_r%0d_key_ready", tag, r), key_ready, 1'b0);
      if (r == hold_at) begin
        snap = sh_round_key;
        for (int h = 0; h < 20; h++) begin
          tick();
          check($sformatf("%s_hold%0d_key", tag, h), sh_round_key, snap);
          check($sformatf("%s_hold%0d_idx", tag, h), rk_index, v.idx);
          check($sformatf("%s_hold%0d_dv", tag, h), {rk_valid, ks_data_valid, ks_active}, 3'b100);
        end
      end
      rk_ready = 1'b1;
      tick();
      rk_ready = 1'b0;
      if (r == NR) begin
        check($sformatf("%s_done_key_ready", tag), key_ready, 1'b1);
        check($sformatf("%s_done_rk_valid", tag), rk_valid, 1'b0);
        check($sformatf("%s_done_dv", tag), ks_data_valid, 1'b0);
        return;
      end
      check($sformatf("%s_r%0d_issue_dv", tag, r), {ks_data_valid, ks_active, rk_valid}, 3'b110);
      for (int k = 2; k <= LAT + 1; k++) begin
        tick();
        if (key_valid) key_valid = 1'b0;
        check($sformatf("%s_r%0d_c%0d_dv", tag, r, k), {ks_data_valid, rk_valid, ks_active}, 3'b001);
        check($sformatf("%s_r%0d_c%0d_rcon_upd", tag, r, k), ks_rcon_update, (k == LAT + 1));
        if (r == inject_at && k == 2) begin
          sh_key_in = share(zero_tbl[0].rk);
          key_valid = 1'b1;
          #1;
          check($sformatf("%s_inject_key_ready", tag), key_ready, 1'b0);
          check($sformatf("%s_inject_rcon_rst", tag), ks_rcon_rst, 1'b0);
        end
        if (r == reset_at && k == 2) begin
          nrst = 1'b0;
          #1;
          check($sformatf("%s_rst_rcon_rst", tag), ks_rcon_rst, 1'b1);
          tick();
          check($sformatf("%s_rst_flags", tag),
                {rk_valid, key_ready, ks_data_valid, ks_active, ks_rcon_update}, 5'b01000);
          check($sformatf("%s_rst_idx", tag), rk_index, 4'd0);
          nrst = 1'b1;
          return;
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    fips_tbl[0]  = '{4'd0,  1'b0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
    fips_tbl[1]  = '{4'd1,  1'b0, 128'ha0fafe17_88542cb1_23a33939_2a6c7605};
    fips_tbl[2]  = '{4'd2,  1'b0, 128'hf2c295f2_7a96b943_5935807a_7359f67f};
    fips_tbl[3]  = '{4'd3,  1'b0, 128'h3d80477d_4716fe3e_1e237e44_6d7a883b};
    fips_tbl[4]  = '{4'd4,  1'b0, 128'hef44a541_a8525b7f_b671253b_db0bad00};
    fips_tbl[5]  = '{4'd5,  1'b0, 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc};
    fips_tbl[6]  = '{4'd6,  1'b0, 128'h6d88a37a_110b3efd_dbf98641_ca0093fd};
    fips_tbl[7]  = '{4'd7,  1'b0, 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f};
    fips_tbl[8]  = '{4'd8,  1'b0, 128'head27321_b58dbad2_312bf560_7f8d292f};
    fips_tbl[9]  = '{4'd9,  1'b0, 128'hac7766f3_19fadc21_28d12941_575c006e};
    fips_tbl[10] = '{4'd10, 1'b1, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
    zero_tbl[0]  = '{4'd0,  1'b0, 128'h00000000_00000000_00000000_00000000};
    zero_tbl[1]  = '{4'd1,  1'b0, 128'h62636363_62636363_62636363_62636363};
    zero_tbl[2]  = '{4'd2,  1'b0, 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa};
    zero_tbl[3]  = '{4'd3,  1'b0, 128'h90973450_696ccffa_f2f45733_0b0fac99};
    zero_tbl[4]  = '{4'd4,  1'b0, 128'hee06da7b_876a1581_759e42b2_7e91ee2b};
    zero_tbl[5]  = '{4'd5,  1'b0, 128'h7f2e2b88_f8443e09_8dda7cbb_f34b9290};
    zero_tbl[6]  = '{4'd6,  1'b0, 128'hec614b85_1425758c_99ff0937_6ab49ba7};
    zero_tbl[7]  = '{4'd7,  1'b0, 128'h21751787_3550620b_acaf6b3c_c61bf09b};
    zero_tbl[8]  = '{4'd8,  1'b0, 128'h0ef90333_3ba96138_97060a04_511dfa9f};
    zero_tbl[9]  = '{4'd9,  1'b0, 128'hb1d4d8e2_8a7db9da_1d7bb3de_4c664941};
    zero_tbl[10] = '{4'd10, 1'b1, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e};

    nrst = 1'b0; key_valid = 1'b0; rk_ready = 1'b0; sh_key_in = '0;
    repeat (3) tick();
    check("rst_rcon_rst_held", ks_rcon_rst, 1'b1);
    nrst = 1'b1;
    tick();
    check("rst_key_ready", key_ready, 1'b1);
    check("rst_flags", {rk_valid, ks_data_valid, ks_rcon_update, ks_active, rk_last, ks_rcon_rst}, '0);
    check("rst_key_reg", sh_ks_key, '0);
    check("rst_rk_index", rk_index, 4'd0);
    tick();
    check("idle_stays_ready", {key_ready, rk_valid}, 2'b10);

    $display("seq fips_basic: ideal schedule with per-round timing");
    load(fips_tbl[0].rk, "basic");
    run_keys(0, -1, -1, -1, "basic");

    $display("seq hold: rk_ready withheld 20 cycles at index 3");
    load(fips_tbl[0].rk, "hold");
    run_keys(0, 3, -1, -1, "hold");

    $display("seq inject: second key offered during WAIT");
    load(fips_tbl[0].rk, "inject");
    run_keys(0, -1, 2, -1, "inject");

    $display("seq reset: nrst low in WAIT of round 5, then reload");
    load(fips_tbl[0].rk, "abort");
    run_keys(0, -1, -1, 4, "abort");
    load(fips_tbl[0].rk, "reload");
    run_keys(0, -1, -1, -1, "reload");

    $display("seq back_to_back: zero key loaded in the IDLE cycle after rk_last");
    load(zero_tbl[0].rk, "b2b");
    run_keys(1, -1, -1, -1, "b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
